// File: rtl/xsm_trigger_ctrl_if.sv
// Signal bundle between the register block / trigger comparator and xsm_trigger_ctrl.
// The master side drives control, configuration and comparator results; the slave is the controller.
interface xsm_trigger_ctrl_if #(
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned TCNT_WIDTH = 8,
    parameter int unsigned TO_WIDTH   = 24
);
    logic                  arm;
    logic                  abort;
    logic                  auto_rearm;
    logic                  cfg_edge_en;
    logic                  cfg_level_en;
    logic [1:0]            cfg_type_mask;
    logic [CNT_WIDTH-1:0]  cfg_pre_len;
    logic [CNT_WIDTH-1:0]  cfg_post_len;
    logic [CNT_WIDTH-1:0]  cfg_holdoff;
    logic [TCNT_WIDTH-1:0] cfg_trig_count;
    logic [TO_WIDTH-1:0]   cfg_timeout;
    logic                  trig_in;
    logic                  trig_type_in;

    logic                  edge_trigger_en;
    logic                  level_trigger_en;
    logic                  capture_en;
    logic                  capture_done;
    logic [CNT_WIDTH-1:0]  trig_pos;
    logic                  forced;
    logic                  busy;
    logic [2:0]            state_o;

    modport master (
        output arm, abort, auto_rearm, cfg_edge_en, cfg_level_en, cfg_type_mask,
               cfg_pre_len, cfg_post_len, cfg_holdoff, cfg_trig_count, cfg_timeout,
               trig_in, trig_type_in,
        input  edge_trigger_en, level_trigger_en, capture_en, capture_done, trig_pos,
               forced, busy, state_o
    );

    modport slave (
        input  arm, abort, auto_rearm, cfg_edge_en, cfg_level_en, cfg_type_mask,
               cfg_pre_len, cfg_post_len, cfg_holdoff, cfg_trig_count, cfg_timeout,
               trig_in, trig_type_in,
        output edge_trigger_en, level_trigger_en, capture_en, capture_done, trig_pos,
               forced, busy, state_o
    );
endinterface

// File: rtl/xsm_trigger_ctrl.sv
// XSM capture sequencer: pre-trigger / wait / post-trigger / holdoff around the trigger comparator.
// Defining XSM_TRIG_TIMEOUT_EN builds the WAIT timeout force-fire and the forced flag.
module xsm_trigger_ctrl #(
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned TCNT_WIDTH = 8,
    parameter int unsigned TO_WIDTH   = 24
) (
    input logic               clk,
    input logic               rst,
    xsm_trigger_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StPre  = 3'd1,
        StWait = 3'd2,
        StPost = 3'd3,
        StDone = 3'd4,
        StHold = 3'd5
    } state_e;

    localparam logic [CNT_WIDTH-1:0]  CntOne  = CNT_WIDTH'(1);
    localparam logic [TCNT_WIDTH-1:0] TcntOne = TCNT_WIDTH'(1);

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  phase_q, phase_d;
    logic [CNT_WIDTH-1:0]  sample_cnt_q, sample_cnt_d;
    logic [CNT_WIDTH-1:0]  trig_pos_q, trig_pos_d;
    logic [TCNT_WIDTH-1:0] occ_q, occ_d;

    // Configuration snapshot taken on every arm or auto-rearm.
    logic [CNT_WIDTH-1:0]  pre_s_q, post_s_q, hold_s_q;
    logic [TCNT_WIDTH-1:0] tcnt_s_q;
    logic [1:0]            mask_s_q;
    logic                  edge_s_q, level_s_q;

    logic                  start, end_seq, qual, fire_real, fire_to, fire;
    logic [TCNT_WIDTH-1:0] target;
    logic [TCNT_WIDTH:0]   occ_inc;

    logic capture_en_d, capture_done_d, busy_d, edge_en_d, level_en_d;
    logic capture_en_q, capture_done_q, busy_q, edge_en_q, level_en_q;

    assign qual      = bus.trig_in && mask_s_q[bus.trig_type_in];
    assign target    = (tcnt_s_q == '0) ? TcntOne : tcnt_s_q;
    assign occ_inc   = {1'b0, occ_q} + {{TCNT_WIDTH{1'b0}}, 1'b1};
    assign fire_real = (state_q == StWait) && qual && (occ_inc >= {1'b0, target});
    assign fire      = fire_real || fire_to;

`ifdef XSM_TRIG_TIMEOUT_EN
    logic [TO_WIDTH-1:0] to_s_q, to_q, to_d;
    logic                forced_q, forced_d;

    // to_q holds the number of completed WAIT cycles; a real fire in the same cycle wins.
    assign to_d    = (state_q == StWait) ? to_q + TO_WIDTH'(1) : '0;
    assign fire_to = (state_q == StWait) && (to_s_q != '0) &&
                     (to_q == to_s_q - TO_WIDTH'(1)) && !fire_real;

    always_comb begin
        forced_d = forced_q;
        if (!bus.abort && fire) forced_d = fire_to;
        if (start) forced_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_s_q   <= '0;
            to_q     <= '0;
            forced_q <= 1'b0;
        end else begin
            to_q     <= to_d;
            forced_q <= forced_d;
            if (start) to_s_q <= bus.cfg_timeout;
        end
    end

    assign bus.forced = forced_q;
`else
    logic [TO_WIDTH-1:0] unused_timeout;
    assign unused_timeout = bus.cfg_timeout;
    assign fire_to        = 1'b0;
    assign bus.forced     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        trig_pos_d = trig_pos_q;
        occ_d      = occ_q;
        start      = 1'b0;
        end_seq    = 1'b0;
        if (bus.abort) begin
            state_d = StIdle;
            phase_d = '0;
        end else begin
            case (state_q)
                StIdle: start = bus.arm;
                StPre: begin
                    if (phase_q == pre_s_q - CntOne) begin
                        state_d = StWait;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + CntOne;
                    end
                end
                StWait: begin
                    if (qual && (occ_q != '1)) occ_d = occ_q + TcntOne;
                    if (fire) begin
                        trig_pos_d = sample_cnt_q;
                        phase_d    = '0;
                        state_d    = (post_s_q == '0) ? StDone : StPost;
                    end
                end
                StPost: begin
                    if (phase_q == post_s_q - CntOne) begin
                        state_d = StDone;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + CntOne;
                    end
                end
                StDone: begin
                    if (hold_s_q == '0) begin
                        end_seq = 1'b1;
                    end else begin
                        state_d = StHold;
                        phase_d = '0;
                    end
                end
                StHold: begin
                    if (phase_q == hold_s_q - CntOne) end_seq = 1'b1;
                    else phase_d = phase_q + CntOne;
                end
                default: begin
                    state_d = StIdle;
                    phase_d = '0;
                end
            endcase
            if (end_seq) begin
                if (bus.auto_rearm) begin
                    start = 1'b1;
                end else begin
                    state_d = StIdle;
                    phase_d = '0;
                end
            end
            // A rearm behaves exactly like a fresh arm, using the live configuration.
            if (start) begin
                state_d = (bus.cfg_pre_len == '0) ? StWait : StPre;
                phase_d = '0;
                occ_d   = '0;
            end
        end
    end

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        if (start) sample_cnt_d = '0;
        else if (capture_en_q) sample_cnt_d = sample_cnt_q + CntOne;
    end

    always_comb begin
        capture_en_d   = state_d inside {StPre, StWait, StPost};
        capture_done_d = (state_d == StDone);
        busy_d         = (state_d != StIdle);
        edge_en_d      = (state_d == StWait) && (start ? bus.cfg_edge_en : edge_s_q);
        level_en_d     = (state_d == StWait) && (start ? bus.cfg_level_en : level_s_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            phase_q        <= '0;
            sample_cnt_q   <= '0;
            trig_pos_q     <= '0;
            occ_q          <= '0;
            pre_s_q        <= '0;
            post_s_q       <= '0;
            hold_s_q       <= '0;
            tcnt_s_q       <= '0;
            mask_s_q       <= '0;
            edge_s_q       <= 1'b0;
            level_s_q      <= 1'b0;
            capture_en_q   <= 1'b0;
            capture_done_q <= 1'b0;
            busy_q         <= 1'b0;
            edge_en_q      <= 1'b0;
            level_en_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            sample_cnt_q   <= sample_cnt_d;
            trig_pos_q     <= trig_pos_d;
            occ_q          <= occ_d;
            capture_en_q   <= capture_en_d;
            capture_done_q <= capture_done_d;
            busy_q         <= busy_d;
            edge_en_q      <= edge_en_d;
            level_en_q     <= level_en_d;
            if (start) begin
                pre_s_q   <= bus.cfg_pre_len;
                post_s_q  <= bus.cfg_post_len;
                hold_s_q  <= bus.cfg_holdoff;
                tcnt_s_q  <= bus.cfg_trig_count;
                mask_s_q  <= bus.cfg_type_mask;
                edge_s_q  <= bus.cfg_edge_en;
                level_s_q <= bus.cfg_level_en;
            end
        end
    end

    assign bus.state_o          = state_q;
    assign bus.capture_en       = capture_en_q;
    assign bus.capture_done     = capture_done_q;
    assign bus.busy             = busy_q;
    assign bus.trig_pos         = trig_pos_q;
    assign bus.edge_trigger_en  = edge_en_q;
    assign bus.level_trigger_en = level_en_q;

endmodule

// File: tb/tb_xsm_trigger_ctrl.sv
// Directed bench for xsm_trigger_ctrl: stimulus pushes expected completions, a monitor checks them.
module tb_xsm_trigger_ctrl;
    localparam int CW = 16;
    localparam int TW = 8;
    localparam int OW = 24;
    localparam int IDLE = 0, PRE = 1, WAIT = 2, POST = 3, DONE = 4, HOLD = 5;

    typedef struct packed {
        logic [CW-1:0] pos;
        logic          forced;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    xsm_trigger_ctrl_if #(.CNT_WIDTH(CW), .TCNT_WIDTH(TW), .TO_WIDTH(OW)) bus ();

    xsm_trigger_ctrl #(.CNT_WIDTH(CW), .TCNT_WIDTH(TW), .TO_WIDTH(OW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int pos, input logic f);
        exp_t e;
        e.pos    = CW'(pos);
        e.forced = f;
        exp_q.push_back(e);
    endtask

    // Every capture_done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (!rst && bus.capture_done) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL done_unexpected: capture_done=1 trig_pos=%0d, expected no pulse",
                         bus.trig_pos);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.trig_pos !== mon_e.pos || bus.forced !== mon_e.forced ||
                    bus.capture_en !== 1'b0) begin
                    failures++;
                    $display("FAIL done_result: trig_pos=%0d forced=%0d cap_en=%0d, expected %0d %0d 0",
                             bus.trig_pos, bus.forced, bus.capture_en, mon_e.pos, mon_e.forced);
                end
            end
        end
    end

    task automatic set_cfg(input int pre, input int post, input int hold, input int cnt,
                           input logic [1:0] mask);
        bus.cfg_pre_len    = CW'(pre);
        bus.cfg_post_len   = CW'(post);
        bus.cfg_holdoff    = CW'(hold);
        bus.cfg_trig_count = TW'(cnt);
        bus.cfg_type_mask  = mask;
    endtask

    task automatic do_arm();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask

    initial begin
        bus.arm = 0; bus.abort = 0; bus.auto_rearm = 0;
        bus.cfg_edge_en = 1; bus.cfg_level_en = 1; bus.cfg_timeout = '0;
        bus.trig_in = 0; bus.trig_type_in = 0;
        set_cfg(4, 3, 0, 1, 2'b11);
        tick(); tick();
        rst = 1'b0;

        chk("rst state", bus.state_o, IDLE);
        chk("rst busy", bus.busy, 0);
        chk("rst capture_en", bus.capture_en, 0);
        chk("rst capture_done", bus.capture_done, 0);
        chk("rst trig_pos", bus.trig_pos, 0);
        chk("rst trig_en", {bus.edge_trigger_en, bus.level_trigger_en, bus.forced}, 0);

        // Basic sequence: capture window 1..11, level trigger at cycle 8.
        push(7, 0);
        do_arm();
        for (int c = 1; c <= 13; c++) begin
            chk($sformatf("t1 capture_en c%0d", c), bus.capture_en, (c <= 11));
            if (c == 1) chk("t1 state PRE", bus.state_o, PRE);
            if (c == 1) chk("t1 level_en off in PRE", bus.level_trigger_en, 0);
            if (c == 5) chk("t1 state WAIT", bus.state_o, WAIT);
            if (c == 5) chk("t1 enables in WAIT", {bus.edge_trigger_en, bus.level_trigger_en}, 3);
            if (c == 12) chk("t1 capture_done", bus.capture_done, 1);
            if (c == 13) chk("t1 busy low", bus.busy, 0);
            bus.trig_in = (c == 8);
            bus.trig_type_in = 1'b0;
            tick();
        end

        // Third edge-type pulse fires; level pulses are masked out.
        set_cfg(2, 1, 0, 3, 2'b10);
        push(11, 0);
        do_arm();
        for (int c = 1; c <= 15; c++) begin
            if (c == 3)  chk("t2 state WAIT c3", bus.state_o, WAIT);
            if (c == 11) chk("t2 still WAIT c11", bus.state_o, WAIT);
            if (c == 13) chk("t2 state POST", bus.state_o, POST);
            if (c == 14) chk("t2 state DONE", bus.state_o, DONE);
            if (c == 15) chk("t2 state IDLE", bus.state_o, IDLE);
            bus.trig_in = (c == 4) || (c == 6) || (c == 8) || (c == 10) || (c == 12);
            bus.trig_type_in = (c == 6) || (c == 8) || (c == 12);
            tick();
        end

        // Zero pre/post lengths.
        set_cfg(0, 0, 0, 1, 2'b11);
        push(2, 0);
        do_arm();
        for (int c = 1; c <= 5; c++) begin
            if (c == 1) chk("t3 straight to WAIT", bus.state_o, WAIT);
            if (c == 1) chk("t3 capture_en", bus.capture_en, 1);
            if (c == 4) chk("t3 DONE after trig", bus.state_o, DONE);
            if (c == 4) chk("t3 capture_done", bus.capture_done, 1);
            if (c == 5) chk("t3 IDLE", bus.state_o, IDLE);
            bus.trig_in = (c == 3);
            bus.trig_type_in = 1'b1;
            tick();
        end

        // Abort during POST, then abort together with arm.
        set_cfg(1, 5, 0, 1, 2'b11);
        do_arm();
        for (int c = 1; c <= 9; c++) begin
            if (c == 3) chk("t4 state POST", bus.state_o, POST);
            if (c == 5) begin
                chk("t4 abort -> IDLE", bus.state_o, IDLE);
                chk("t4 abort capture_en", bus.capture_en, 0);
                chk("t4 trig_pos kept", bus.trig_pos, 1);
            end
            if (c == 6) chk("t4 arm+abort ignored", {bus.state_o, bus.busy}, 0);
            bus.trig_in = (c == 2);
            bus.trig_type_in = 1'b0;
            bus.abort = (c == 4) || (c == 5);
            bus.arm = (c == 5);
            tick();
        end

        // Auto-rearm with holdoff 5; mid-sequence cfg change must not take effect.
        set_cfg(2, 1, 5, 1, 2'b11);
        bus.auto_rearm = 1'b1;
        push(2, 0);
        push(2, 0);
        do_arm();
        for (int c = 1; c <= 22; c++) begin
            if (c == 3)  chk("t5 WAIT", bus.state_o, WAIT);
            if (c == 5)  chk("t5 DONE", bus.state_o, DONE);
            if (c == 6)  chk("t5 HOLD start", bus.state_o, HOLD);
            if (c == 8)  chk("t5 arm in HOLD ignored", bus.state_o, HOLD);
            if (c == 10) chk("t5 HOLD end", bus.state_o, HOLD);
            if (c == 11) chk("t5 rearm PRE", {bus.state_o, bus.capture_en}, {3'(PRE), 1'b1});
            if (c == 13) chk("t5 cfg change ignored", bus.state_o, WAIT);
            if (c == 15) chk("t5 second DONE", bus.state_o, DONE);
            if (c == 20) chk("t5 second HOLD", bus.state_o, HOLD);
            if (c == 21) chk("t5 back to IDLE", bus.state_o, IDLE);
            if (c == 11) begin
                bus.auto_rearm = 1'b0;
                bus.cfg_pre_len = CW'(9);
            end
            bus.arm = (c == 7);
            bus.trig_in = (c == 3) || (c == 13);
            bus.trig_type_in = 1'b0;
            tick();
        end

        // WAIT timeout with no trigger.
        set_cfg(0, 0, 0, 1, 2'b11);
        bus.cfg_timeout = OW'(10);
`ifdef XSM_TRIG_TIMEOUT_EN
        push(9, 1);
        do_arm();
        for (int c = 1; c <= 13; c++) begin
            if (c == 1)  chk("t6 WAIT forced=0", {bus.state_o, bus.forced}, {3'(WAIT), 1'b0});
            if (c == 10) chk("t6 still WAIT c10", bus.state_o, WAIT);
            if (c == 11) chk("t6 forced DONE", {bus.state_o, bus.forced}, {3'(DONE), 1'b1});
            if (c == 12) chk("t6 forced held", {bus.state_o, bus.forced}, {3'(IDLE), 1'b1});
            if (c == 13) chk("t6 forced cleared", {bus.state_o, bus.forced}, {3'(WAIT), 1'b0});
            bus.arm = (c == 12);
            bus.abort = (c == 13);
            tick();
        end
`else
        do_arm();
        for (int c = 1; c <= 30; c++) begin
            if (c == 11 || c == 30)
                chk($sformatf("t6 no timeout c%0d", c), {bus.state_o, bus.forced},
                    {3'(WAIT), 1'b0});
            bus.abort = (c == 30);
            tick();
        end
`endif
        bus.abort = 1'b0;
        bus.cfg_timeout = '0;
        tick();

        // Reset in the middle of a sequence.
        set_cfg(4, 3, 0, 1, 2'b11);
        do_arm();
        tick(); tick();
        chk("t7 pre-reset PRE", bus.state_o, PRE);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t7 reset state", {bus.state_o, bus.busy, bus.capture_en}, 0);
        chk("t7 reset trig_pos", bus.trig_pos, 0);

        tick(); tick(); tick();
        chk("scoreboard drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
